// File: rtl/multibank_fifo_pkg.sv
// Shared types and helpers for the multi-bank ping-pong FIFO.
package multibank_fifo_pkg;

    typedef enum logic [1:0] {FREE, FILL, SEALED, DRAIN} bank_state_t;

    function automatic bit mode_is(input string mode, input string val);
        return mode == val;
    endfunction

endpackage

// File: rtl/fifo_bank.sv
// One FIFO bank: word storage, fill length and FREE/FILL/SEALED/DRAIN lifecycle.
module fifo_bank
    import multibank_fifo_pkg::*;
#(
    parameter int unsigned DSIZE = 32,
    parameter int unsigned ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             seal,
    input  logic             rd,
    input  logic             rel,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata,
    output bank_state_t      state,
    output logic [ASIZE:0]   len
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned LW    = ASIZE + 1;

    logic [DSIZE-1:0] mem [DEPTH];
    bank_state_t      state_q, state_d;
    logic [ASIZE:0]   len_q, len_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    // Writer (we/seal) and reader (rd/rel) never target the same bank in one cycle.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        if (we) begin
            len_d = {1'b0, waddr} + LW'(1);
            if (state_q == FREE) begin
                state_d = FILL;
            end
        end
        if (seal) begin
            state_d = SEALED;
        end
        if (rd) begin
            state_d = DRAIN;
        end
        if (rel) begin
            state_d = FREE;
            len_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FREE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    assign state = state_q;
    assign len   = len_q;

endmodule

// File: rtl/multibank_pingpong_fifo.sv
// N-bank ping-pong FIFO: writer fills and seals banks in turn, reader drains sealed banks in order.
module multibank_pingpong_fifo
    import multibank_fifo_pkg::*;
#(
    parameter int unsigned DSIZE       = 32,
    parameter int unsigned ASIZE       = 4,
    parameter int unsigned NBANKS      = 2,
    parameter int unsigned AWFULLSIZE  = 4,
    parameter int unsigned AREMPTYSIZE = 4,
    parameter string       FALLTHROUGH = "TRUE"
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              winc,
    input  logic [DSIZE-1:0]                  wdata,
    input  logic                              flush,
    output logic                              wfull,
    output logic                              awfull,
    input  logic                              rinc,
    output logic [DSIZE-1:0]                  rdata,
    output logic                              rempty,
    output logic                              arempty,
    output logic [NBANKS-1:0]                 bank_sealed,
    output logic [ASIZE+$clog2(NBANKS):0]     rcount
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned TOTAL = NBANKS * DEPTH;
    localparam int unsigned BW    = $clog2(NBANKS);
    localparam int unsigned LW    = ASIZE + 1;
    localparam int unsigned RCW   = ASIZE + $clog2(NBANKS) + 1;
    localparam bit          FallThrough = mode_is(FALLTHROUGH, "TRUE");

    function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
        return (b == BW'(NBANKS - 1)) ? '0 : b + BW'(1);
    endfunction

    bank_state_t      bank_state [NBANKS];
    logic [ASIZE:0]   bank_len   [NBANKS];
    logic [DSIZE-1:0] bank_rdata [NBANKS];
    logic [NBANKS-1:0] bank_we, bank_seal, bank_rd, bank_rel;

    logic [BW-1:0]    wbank_q, wbank_d, rbank_q, rbank_d;
    logic [ASIZE-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic             wr_en, flush_ok, seal, rd_en, rd_last;
    logic [RCW-1:0]   occupied;
    logic [DSIZE-1:0] head;

    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
        assign bank_sealed[i] = (bank_state[i] == SEALED) || (bank_state[i] == DRAIN);

        fifo_bank #(
            .DSIZE (DSIZE),
            .ASIZE (ASIZE)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bank_we[i]),
            .waddr (waddr_q),
            .wdata (wdata),
            .seal  (bank_seal[i]),
            .rd    (bank_rd[i]),
            .rel   (bank_rel[i]),
            .raddr (raddr_q),
            .rdata (bank_rdata[i]),
            .state (bank_state[i]),
            .len   (bank_len[i])
        );
    end

    always_comb begin
        wfull    = bank_sealed[wbank_q];
        wr_en    = winc && !wfull;
        // Flush seals only a bank that holds (or is receiving) at least one word.
        flush_ok = flush && !wfull && (wr_en || (waddr_q != '0));
        seal     = flush_ok || (wr_en && (waddr_q == ASIZE'(DEPTH - 1)));
        wbank_d  = wbank_q;
        waddr_d  = waddr_q;
        if (seal) begin
            wbank_d = bank_inc(wbank_q);
            waddr_d = '0;
        end else if (wr_en) begin
            waddr_d = waddr_q + ASIZE'(1);
        end
        bank_we            = '0;
        bank_seal          = '0;
        bank_we[wbank_q]   = wr_en;
        bank_seal[wbank_q] = seal;
    end

    always_comb begin
        rempty  = !bank_sealed[rbank_q];
        rd_en   = rinc && !rempty;
        rd_last = ({1'b0, raddr_q} == (bank_len[rbank_q] - LW'(1)));
        head    = bank_rdata[rbank_q];
        rbank_d = rbank_q;
        raddr_d = raddr_q;
        if (rd_en && rd_last) begin
            rbank_d = bank_inc(rbank_q);
            raddr_d = '0;
        end else if (rd_en) begin
            raddr_d = raddr_q + ASIZE'(1);
        end
        bank_rd           = '0;
        bank_rel          = '0;
        bank_rd[rbank_q]  = rd_en;
        bank_rel[rbank_q] = rd_en && rd_last;
    end

    always_comb begin
        rcount = '0;
        for (int i = 0; i < NBANKS; i++) begin
            if (bank_state[i] == SEALED) begin
                rcount = rcount + RCW'(bank_len[i]);
            end else if (bank_state[i] == DRAIN) begin
                rcount = rcount + RCW'(bank_len[i] - {1'b0, raddr_q});
            end
        end
        occupied = rcount + ((bank_state[wbank_q] == FILL) ? RCW'(waddr_q) : '0);
        awfull   = (32'(TOTAL) - 32'(occupied)) <= 32'(AWFULLSIZE);
        arempty  = 32'(rcount) <= 32'(AREMPTYSIZE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank_q <= '0;
            waddr_q <= '0;
            rbank_q <= '0;
            raddr_q <= '0;
        end else begin
            wbank_q <= wbank_d;
            waddr_q <= waddr_d;
            rbank_q <= rbank_d;
            raddr_q <= raddr_d;
        end
    end

    if (FallThrough) begin : g_ft
        assign rdata = rempty ? '0 : head;
    end else begin : g_reg
        logic [DSIZE-1:0] rdata_q, rdata_d;

        always_comb begin
            rdata_d = rd_en ? head : rdata_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end

endmodule

// File: tb/tb_multibank_pingpong_fifo.sv
// Randomised bench for multibank_pingpong_fifo (both read modes) against a block-queue model.
module tb_multibank_pingpong_fifo;

    localparam int NB    = 3;
    localparam int DEPTH = 4;
    localparam int TOTAL = NB * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        winc = 1'b0, flush = 1'b0, rinc = 1'b0;
    logic [31:0] wdata = '0;

    logic        wfull_ft, awfull_ft, rempty_ft, arempty_ft;
    logic        wfull_rg, awfull_rg, rempty_rg, arempty_rg;
    logic [31:0] rdata_ft, rdata_rg;
    logic [2:0]  bs_ft, bs_rg;
    logic [4:0]  rcount_ft, rcount_rg;

    always #5 clk = ~clk;

    multibank_pingpong_fifo #(
        .DSIZE(32), .ASIZE(2), .NBANKS(3), .AWFULLSIZE(1), .AREMPTYSIZE(1), .FALLTHROUGH("TRUE")
    ) dut_ft (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .flush(flush),
        .wfull(wfull_ft), .awfull(awfull_ft), .rinc(rinc), .rdata(rdata_ft),
        .rempty(rempty_ft), .arempty(arempty_ft), .bank_sealed(bs_ft), .rcount(rcount_ft)
    );

    multibank_pingpong_fifo #(
        .DSIZE(32), .ASIZE(2), .NBANKS(3), .AWFULLSIZE(1), .AREMPTYSIZE(1), .FALLTHROUGH("FALSE")
    ) dut_rg (
        .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .flush(flush),
        .wfull(wfull_rg), .awfull(awfull_rg), .rinc(rinc), .rdata(rdata_rg),
        .rempty(rempty_rg), .arempty(arempty_rg), .bank_sealed(bs_rg), .rcount(rcount_rg)
    );

    // Model: readable words in order, lengths of sealed blocks, words of the open block.
    logic [31:0] m_rd[$];
    int          m_blk[$];
    logic [31:0] m_fill[$];
    int          m_hb, m_head;
    logic [31:0] m_rreg;
    int          n_vec, n_err, n_read;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd.delete();
        m_blk.delete();
        m_fill.delete();
        m_hb = 0;
        m_head = 0;
        m_rreg = '0;
    endtask

    task automatic model_clock(input bit w, input logic [31:0] d, input bit f, input bit r);
        bit full_pre, empty_pre;
        full_pre  = (m_blk.size() == NB);
        empty_pre = (m_rd.size() == 0);
        if (r && !empty_pre) begin
            m_rreg = m_rd.pop_front();
            n_read++;
            m_head++;
            if (m_head == m_blk[0]) begin
                void'(m_blk.pop_front());
                m_hb = (m_hb + 1) % NB;
                m_head = 0;
            end
        end
        if (!full_pre) begin
            if (w) m_fill.push_back(d);
            if (m_fill.size() == DEPTH || (f && m_fill.size() > 0)) begin
                foreach (m_fill[k]) m_rd.push_back(m_fill[k]);
                m_blk.push_back(m_fill.size());
                m_fill.delete();
            end
        end
    endtask

    task automatic check_all();
        logic [2:0]  e_bs;
        int          cnt;
        logic [31:0] e_ft;
        bit          e_full, e_afull, e_empty, e_aempty;
        e_bs = '0;
        for (int k = 0; k < m_blk.size(); k++) e_bs[(m_hb + k) % NB] = 1'b1;
        cnt      = m_rd.size();
        e_empty  = (cnt == 0);
        e_aempty = (cnt <= 1);
        e_full   = (m_blk.size() == NB);
        e_afull  = (TOTAL - cnt - m_fill.size()) <= 1;
        e_ft     = e_empty ? 32'h0 : m_rd[0];
        check_eq("ft_rempty", rempty_ft, e_empty);
        check_eq("ft_arempty", arempty_ft, e_aempty);
        check_eq("ft_wfull", wfull_ft, e_full);
        check_eq("ft_awfull", awfull_ft, e_afull);
        check_eq("ft_bank_sealed", bs_ft, e_bs);
        check_eq("ft_rcount", rcount_ft, cnt);
        check_eq("ft_rdata", rdata_ft, e_ft);
        check_eq("rg_rempty", rempty_rg, e_empty);
        check_eq("rg_arempty", arempty_rg, e_aempty);
        check_eq("rg_wfull", wfull_rg, e_full);
        check_eq("rg_awfull", awfull_rg, e_afull);
        check_eq("rg_bank_sealed", bs_rg, e_bs);
        check_eq("rg_rcount", rcount_rg, cnt);
        check_eq("rg_rdata", rdata_rg, m_rreg);
    endtask

    task automatic step(input bit w, input logic [31:0] d, input bit f, input bit r);
        winc = w;
        wdata = d;
        flush = f;
        rinc = r;
        @(posedge clk);
        model_clock(w, d, f, r);
        #1;
        winc = 1'b0;
        flush = 1'b0;
        rinc = 1'b0;
        check_all();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int written, cycles;
        bit w, f;
        n_vec = 0;
        n_err = 0;
        n_read = 0;
        model_reset();
        #12;
        // 1: reset state
        check_all();
        check_eq("t1_awfull", awfull_ft, 1'b0);
        check_eq("t1_sealed", bs_rg, 3'b000);
        rst_n = 1'b1;

        // 2: one full bank through
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        check_eq("t2_sealed", bs_ft, 3'b001);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            check_eq("t2_rdata", rdata_rg, 32'(i));
        end
        check_eq("t2_rempty", rempty_ft, 1'b1);

        // 3: fill all banks, 13th write dropped
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
            check_eq("t3_wfull", wfull_rg, (i >= 11));
            check_eq("t3_awfull", awfull_ft, (i >= 10));
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            check_eq("t3_rdata", rdata_rg, 32'(i));
        end
        check_eq("t3_rempty", rempty_rg, 1'b1);

        // 4: flush emits a partial block
        apply_reset();
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_eq("t4_sealed", bs_ft, 3'b001);
        check_eq("t4_rcount", rcount_ft, 5'd2);
        step(1'b0, '0, 1'b0, 1'b1);
        check_eq("t4_rd0", rdata_rg, 32'hA);
        step(1'b0, '0, 1'b0, 1'b1);
        check_eq("t4_rd1", rdata_rg, 32'hB);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        check_eq("t4_bank1", bs_ft, 3'b010);
        step(1'b0, '0, 1'b0, 1'b1);

        // 5: 40-word stream, random reader stalls, flush on every 7th write
        apply_reset();
        n_read = 0;
        written = 0;
        cycles = 0;
        while ((written < 40 || m_rd.size() > 0 || m_fill.size() > 0) && cycles < 2000) begin
            w = (written < 40);
            f = (w && (written % 7 == 6)) || (!w && m_fill.size() > 0);
            if (w && m_blk.size() != NB) begin
                step(w, 32'h1000 + 32'(written), f, ($urandom_range(0, 2) != 0));
                written++;
            end else begin
                step(w, 32'h1000 + 32'(written), f, ($urandom_range(0, 2) != 0));
            end
            cycles++;
        end
        check_eq("t5_all_read", n_read, 40);

        // Free-running random traffic
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        // 6: reset mid-operation discards everything
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 32'hEE00 + 32'(i), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check_eq("t6_rempty", rempty_ft, 1'b1);
        check_eq("t6_wfull", wfull_rg, 1'b0);
        #2;
        rst_n = 1'b1;
        step(1'b1, 32'h55, 1'b1, 1'b0);
        check_eq("t6_ft_head", rdata_ft, 32'h55);
        step(1'b0, '0, 1'b0, 1'b1);
        check_eq("t6_rdata", rdata_rg, 32'h55);
        check_eq("t6_empty", rempty_rg, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
